// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the ALU instruction sequencer: control-step state
// encoding, opcode map, IR field positions and opcode classification helpers.
// No ports; imported by alu_op_sequencer and reg_onehot_decoder.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6,
    T6   = 3'd7
  } state_t;

  localparam int OPC_W     = 5;
  localparam int REG_IDX_W = 4;

  // Low bit of each IR field; fields run upward from here.
  localparam int IR_OPC_LO = 27;
  localparam int IR_RA_LO  = 23;
  localparam int IR_RB_LO  = 19;
  localparam int IR_RC_LO  = 15;

  localparam logic [OPC_W-1:0] OP_ADD = 5'd3;
  localparam logic [OPC_W-1:0] OP_SUB = 5'd4;
  localparam logic [OPC_W-1:0] OP_AND = 5'd5;
  localparam logic [OPC_W-1:0] OP_OR  = 5'd6;
  localparam logic [OPC_W-1:0] OP_SHR = 5'd7;
  localparam logic [OPC_W-1:0] OP_SHL = 5'd9;
  localparam logic [OPC_W-1:0] OP_ROR = 5'd10;
  localparam logic [OPC_W-1:0] OP_ROL = 5'd11;
  localparam logic [OPC_W-1:0] OP_MUL = 5'd15;
  localparam logic [OPC_W-1:0] OP_DIV = 5'd16;
  localparam logic [OPC_W-1:0] OP_NEG = 5'd17;
  localparam logic [OPC_W-1:0] OP_NOT = 5'd18;

  // Opcodes this sequencer knows how to run as a three-register ALU op.
  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Ops producing a HI/LO pair that needs the extra T6 write-back step.
  function automatic logic is_wide_op(input logic [OPC_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/reg_onehot_decoder.sv
// Converts a register index plus enable into a one-hot register strobe.
// Ports: idx (register index), en (strobe enable), onehot (NUM_REGS wide).
// Pure combinational; an index outside NUM_REGS yields all zeros.
module reg_onehot_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [REG_IDX_W-1:0] idx,
  input  logic                 en,
  output logic [NUM_REGS-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (32'(idx) == i)) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control sequencer for three-register ALU instructions: fetch T0-T2, execute T3-T5/T6.
// Ports: clk/clr (sync active-low), start, mem_ready, ir in; busy/done/illegal, datapath
// strobes, one-hot reg_out/reg_enable and alu_op out. Narrow op 6 cycles, wide 7, +1 per T1 wait.
module alu_op_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OPCODE_W = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   ir,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                pc_out,
  output logic                mar_enable,
  output logic                inc_pc,
  output logic                pc_enable,
  output logic                read,
  output logic                mdr_enable,
  output logic                mdr_out,
  output logic                ir_enable,
  output logic                y_enable,
  output logic                z_enable,
  output logic                zlow_out,
  output logic                zhigh_out,
  output logic                lo_enable,
  output logic                hi_enable,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_enable,
  output logic [OPCODE_W-1:0] alu_op
);

  state_t state_q, state_d;

  logic [OPCODE_W-1:0]  op_q;
  logic [REG_IDX_W-1:0] ra_q, rc_q;

  // Fields straight off the IR; only consumed in T3, where they are also latched.
  logic [OPCODE_W-1:0]  ir_opc;
  logic [REG_IDX_W-1:0] ir_ra, ir_rb, ir_rc;
  logic                 ir_legal;
  logic                 ir_low_unused;

  assign ir_opc = ir[IR_OPC_LO +: OPCODE_W];
  assign ir_ra  = ir[IR_RA_LO  +: REG_IDX_W];
  assign ir_rb  = ir[IR_RB_LO  +: REG_IDX_W];
  assign ir_rc  = ir[IR_RC_LO  +: REG_IDX_W];
  assign ir_low_unused = ^ir[IR_RC_LO-1:0];

  function automatic logic idx_ok(input logic [REG_IDX_W-1:0] idx);
    return 32'(idx) < 32'(NUM_REGS);
  endfunction

  assign ir_legal = is_alu_op(OPC_W'(ir_opc)) && idx_ok(ir_ra) && idx_ok(ir_rb) && idx_ok(ir_rc);

  // Register-bus drive and register-load requests feeding the one-hot decoders.
  logic                 rd_en, wr_en;
  logic [REG_IDX_W-1:0] rd_idx;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      // rb is only needed in T3 itself, so it is used directly from the IR.
      if (state_q == T3) begin
        op_q <= ir_opc;
        ra_q <= ir_ra;
        rc_q <= ir_rc;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    busy       = (state_q != IDLE);
    done       = 1'b0;
    illegal    = 1'b0;
    pc_out     = 1'b0;
    mar_enable = 1'b0;
    inc_pc     = 1'b0;
    pc_enable  = 1'b0;
    read       = 1'b0;
    mdr_enable = 1'b0;
    mdr_out    = 1'b0;
    ir_enable  = 1'b0;
    y_enable   = 1'b0;
    z_enable   = 1'b0;
    zlow_out   = 1'b0;
    zhigh_out  = 1'b0;
    lo_enable  = 1'b0;
    hi_enable  = 1'b0;
    alu_op     = '0;
    rd_en      = 1'b0;
    rd_idx     = ir_rb;
    wr_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = T0;
      end
      T0: begin
        pc_out     = 1'b1;
        mar_enable = 1'b1;
        inc_pc     = 1'b1;
        pc_enable  = 1'b1;
        state_d    = T1;
      end
      T1: begin
        read       = 1'b1;
        mdr_enable = 1'b1;
        if (mem_ready) state_d = T2;
      end
      T2: begin
        mdr_out   = 1'b1;
        ir_enable = 1'b1;
        state_d   = T3;
      end
      T3: begin
        if (ir_legal) begin
          rd_en    = 1'b1;
          rd_idx   = ir_rb;
          y_enable = 1'b1;
          state_d  = T4;
        end else begin
          illegal = 1'b1;
          state_d = IDLE;
        end
      end
      T4: begin
        rd_en    = 1'b1;
        rd_idx   = rc_q;
        z_enable = 1'b1;
        alu_op   = op_q;
        state_d  = T5;
      end
      T5: begin
        zlow_out = 1'b1;
        if (is_wide_op(OPC_W'(op_q))) begin
          lo_enable = 1'b1;
          state_d   = T6;
        end else begin
          wr_en   = 1'b1;
          done    = 1'b1;
          state_d = start ? T0 : IDLE;
        end
      end
      T6: begin
        zhigh_out = 1'b1;
        hi_enable = 1'b1;
        done      = 1'b1;
        state_d   = start ? T0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reads happen only in T3/T4 and the write only in narrow T5, so the two
  // buses can never be active together.
  reg_onehot_decoder #(.NUM_REGS(NUM_REGS)) u_rd_dec (
    .idx    (rd_idx),
    .en     (rd_en),
    .onehot (reg_out)
  );

  reg_onehot_decoder #(.NUM_REGS(NUM_REGS)) u_wr_dec (
    .idx    (ra_q),
    .en     (wr_en),
    .onehot (reg_enable)
  );

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Parametrised control sequencer for three-register ALU instructions. It generates the fetch (T0–T2) and execute (T3–T5/T6) control steps that drive `Datapath`, replacing hand-sequenced control. Beyond fixed T0–T5 stepping it adds:
- a memory-ready wait state;
- a configurable register-file size;
- two-word (HI/LO) results for wide ops;
- illegal-instruction detection;
- back-to-back instruction issue.

## Interface
Parameters:
- `DATA_W`, 32, word/IR width
- `NUM_REGS`, 16, general registers; width of one-hot `reg_out`/`reg_enable` (2..16)
- `OPCODE_W`, 5, opcode field width, IR[31:27]

Ports:
- `clk`  in  1  clock, all state changes on rising edge
- `clr`  in  1  reset, synchronous, active-low
- `start`  in  1  request an instruction cycle; sampled in IDLE and in the done cycle
- `mem_ready`  in  1  memory read data valid on `Mdatain`
- `ir`  in  DATA_W  current IR contents
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse in the final execute state
- `illegal`  out  1  one-cycle pulse on rejected instruction
- `pc_out`, `mar_enable`, `inc_pc`, `pc_enable`, `read`, `mdr_enable`, `mdr_out`, `ir_enable`, `y_enable`, `z_enable`, `zlow_out`, `zhigh_out`, `lo_enable`, `hi_enable`  out  1 each  datapath strobes
- `reg_out`  out  NUM_REGS  one-hot register bus drive
- `reg_enable`  out  NUM_REGS  one-hot register load
- `alu_op`  out  OPCODE_W  ALU operation select

## Operation
IR fields:
- `opcode` = IR[31:27]
- `ra` (destination) = IR[26:23]
- `rb` = IR[22:19]
- `rc` = IR[18:15]

Example: 0x28918000 encodes AND R1,R2,R3.

Outputs are a Moore decode of the state register plus latched fields. Every strobe not listed for a state is 0.
- IDLE: all outputs 0. `start`=1 → T0.
- T0: `pc_out`, `mar_enable`, `inc_pc`, `pc_enable` → T1.
- T1: `read`, `mdr_enable`. Stays in T1 while `mem_ready`=0; `mem_ready`=1 → T2.
- T2: `mdr_out`, `ir_enable` → T3.
- T3: latch `opcode`/`ra`/`rb`/`rc` from `ir` this cycle, then check:
  - If `opcode` is not in the package ALU set, or any index ≥ NUM_REGS: `illegal`=1 only, no strobes, → IDLE.
  - Otherwise: `reg_out[rb]`, `y_enable` → T4.
- T4: `reg_out[rc]`, `z_enable`, `alu_op`=opcode → T5.
- T5, narrow op: `zlow_out`, `reg_enable[ra]`, `done` → next state per the done rule below.
- T5, wide op (MUL/DIV): `zlow_out`, `lo_enable` → T6.
- T6: `zhigh_out`, `hi_enable`, `done` → next state per the done rule below.
- Done rule: from the done cycle, `start`=1 → T0 (back-to-back), else → IDLE.
- `alu_op` is 0 outside T4.

Boundary rules:
- `start` outside IDLE/done cycle: ignored.
- `clr`=0 in any state, including T1 wait: next edge → IDLE, all outputs 0, latched fields 0.
- `ra`=0 is a legal destination.
- `ra`=`rb`=`rc` is legal: the read in T3/T4 precedes the write in T5.
- `reg_out` and `reg_enable` never have more than one bit set.
- `reg_out` and `reg_enable` are never both nonzero in the same cycle.

## Timing
- All outputs after reset: 0; state IDLE.
- `start` sampled high at edge k → T0 occupies cycle k+1.
- Narrow op, zero wait: 6 cycles, T0..T5; `done` in cycle k+6.
- Wide op: 7 cycles; `done` in cycle k+7.
- Each memory wait cycle adds 1 cycle.
- `mem_ready` already high on T1 entry → T1 lasts exactly 1 cycle.
- Illegal: `illegal` in cycle k+4; IDLE at k+5; `done` never asserted.
- Back-to-back issue: T0 of the next instruction immediately follows the done cycle, with no IDLE gap.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum (IDLE, T0–T6);
  - opcode constants (ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, MUL, DIV, NEG, NOT);
  - the ALU-legal and wide-op membership functions;
  - IR field bit positions.
- Sub-module `reg_onehot_decoder` (parameter NUM_REGS) converts an index plus enable into a one-hot vector; instantiated once for `reg_out` and once for `reg_enable`.

## Test plan
- `ir`=0x28918000 (AND R1,R2,R3), `mem_ready` tied 1, `start` pulse → T0..T5 in 6 cycles:
  - T3: `reg_out`=0x0004, `y_enable`=1
  - T4: `reg_out`=0x0008, `alu_op`=5'b00101, `z_enable`=1
  - T5: `reg_enable`=0x0002, `zlow_out`=1, `done`=1
  - then IDLE
- Same instruction with `mem_ready` low for 3 cycles → T1 held for 4 cycles, `done` 3 cycles later than the zero-wait case, all other strobes unchanged.
- MUL opcode, `rb`=4, `rc`=5 → T5: `zlow_out`+`lo_enable`; T6: `zhigh_out`+`hi_enable`+`done`; `reg_enable` stays 0 throughout.
- Opcode 5'b11111, or NUM_REGS=8 with `ra`=9 → `illegal` pulse in T3, no register strobes, no `done`, IDLE next cycle.
- `start` held high across two instructions → second T0 immediately after first `done`; `start` pulses during T2 are ignored.
- `clr`=0 asserted while in T4 → next edge: all outputs 0, `busy`=0; a `start` after reset runs a clean T0.
